// File: rtl/img_arb_pkg.sv
// Shared types and constants for the image-processing core arbiter.
package img_arb_pkg;

    localparam int DEFAULT_COLOR_SIZE = 8;
    localparam int JOB_BEATS_W        = 16;

    typedef logic [1:0] grant_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CFG    = 2'd1,
        ACTIVE = 2'd2
    } arb_state_e;

    // After a job the pointer favours whichever slave did not own the core.
    // For a one-hot grant that index is simply bit 0.
    function automatic logic nextRrPtr(input grant_t grant);
        return grant[0];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker: a lone request always wins, a tie goes to rr_ptr.
module rr_arbiter2
    import img_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output grant_t     pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = rr_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/img_proc_arbiter.sv
// Whole-job round-robin arbiter sharing one image-processing core between two slaves.
// Optional stall watchdog is built only when ARB_TIMEOUT_EN is defined.
module img_proc_arbiter
    import img_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = DEFAULT_COLOR_SIZE
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             slv0_mode,
    input  logic [COLOR_SIZE-1:0]  slv0_proc_val,
    input  logic                   slv0_data_valid,
    input  logic [DATA_WIDTH-1:0]  slv0_data,
    output logic                   slv0_ready,
    input  logic [1:0]             slv1_mode,
    input  logic [COLOR_SIZE-1:0]  slv1_proc_val,
    input  logic                   slv1_data_valid,
    input  logic [DATA_WIDTH-1:0]  slv1_data,
    output logic                   slv1_ready,
    output logic                   core_start,
    output logic [1:0]             core_mode,
    output logic [COLOR_SIZE-1:0]  core_proc_val,
    output logic                   core_data_valid,
    output logic [DATA_WIDTH-1:0]  core_data,
    input  logic                   core_ready,
    input  logic                   core_cmplt,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic [JOB_BEATS_W-1:0] job_beats,
    output logic                   timeout_err
);

    arb_state_e             r_state;
    grant_t                 r_grant;
    logic                   r_rrPtr;
    logic [1:0]             r_mode;
    logic [COLOR_SIZE-1:0]  r_procVal;
    logic [JOB_BEATS_W-1:0] r_jobBeats;

    logic [1:0] w_req;
    grant_t     w_pick;
    logic       w_active;
    logic       w_beat;
    logic       w_timeout;

    assign w_req    = {slv1_data_valid, slv0_data_valid};
    assign w_active = (r_state == ACTIVE);

    rr_arbiter2 u_rrArbiter (
        .req    (w_req),
        .rr_ptr (r_rrPtr),
        .pick   (w_pick)
    );

    // The data path is a pure mux; everything is gated off outside ACTIVE.
    assign core_data_valid = w_active & ((r_grant[0] & slv0_data_valid) |
                                         (r_grant[1] & slv1_data_valid));
    assign slv0_ready      = w_active & r_grant[0] & core_ready;
    assign slv1_ready      = w_active & r_grant[1] & core_ready;
    assign w_beat          = core_data_valid & core_ready;

    always_comb begin
        core_data = '0;
        if (w_active && r_grant[0]) begin
            core_data = slv0_data;
        end else if (w_active && r_grant[1]) begin
            core_data = slv1_data;
        end
    end

    assign core_start    = (r_state == CFG);
    assign busy          = (r_state != IDLE);
    assign grant         = r_grant;
    assign core_mode     = r_mode;
    assign core_proc_val = r_procVal;
    assign job_beats     = r_jobBeats;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rrPtr    <= 1'b0;
            r_mode     <= '0;
            r_procVal  <= '0;
            r_jobBeats <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant    <= w_pick;
                        r_mode     <= w_pick[0] ? slv0_mode : slv1_mode;
                        r_procVal  <= w_pick[0] ? slv0_proc_val : slv1_proc_val;
                        r_jobBeats <= '0;
                        r_state    <= CFG;
                    end
                end
                CFG: begin
                    r_state <= ACTIVE;
                end
                ACTIVE: begin
                    // A final beat coinciding with completion is still counted.
                    if (w_beat && (r_jobBeats != '1)) begin
                        r_jobBeats <= r_jobBeats + 1'b1;
                    end
                    if (core_cmplt || w_timeout) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_rrPtr <= nextRrPtr(r_grant);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_stallCnt;
    logic             r_timeoutErr;

    // The abort fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
    assign w_timeout   = w_active & ~w_beat & (r_stallCnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeoutErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt   <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_timeoutErr <= w_timeout & ~core_cmplt;
            if ((r_state == CFG) || w_beat || w_timeout) begin
                r_stallCnt <= '0;
            end else if (w_active) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_img_proc_arbiter.sv
// Scoreboard bench for img_proc_arbiter; watchdog checks run when ARB_TIMEOUT_EN is defined.
module tb_img_proc_arbiter;

    localparam int DW = 32;
    localparam int CS = 8;

    logic          clk;
    logic          rst;
    logic [1:0]    slv0_mode;
    logic [CS-1:0] slv0_proc_val;
    logic          slv0_data_valid;
    logic [DW-1:0] slv0_data;
    logic          slv0_ready;
    logic [1:0]    slv1_mode;
    logic [CS-1:0] slv1_proc_val;
    logic          slv1_data_valid;
    logic [DW-1:0] slv1_data;
    logic          slv1_ready;
    logic          core_start;
    logic [1:0]    core_mode;
    logic [CS-1:0] core_proc_val;
    logic          core_data_valid;
    logic [DW-1:0] core_data;
    logic          core_ready;
    logic          core_cmplt;
    logic [1:0]    grant;
    logic          busy;
    logic [15:0]   job_beats;
    logic          timeout_err;

    typedef struct {
        logic [1:0]    g;
        logic [1:0]    m;
        logic [CS-1:0] p;
    } cfgExp_t;

    cfgExp_t       cfgQ[$];
    logic [DW-1:0] dataQ[$];
    cfgExp_t       monCfg;
    logic [DW-1:0] monData;

    int nVec = 0;
    int nMis = 0;

    img_proc_arbiter #(
        .DATA_WIDTH (DW),
        .COLOR_SIZE (CS)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .slv0_mode       (slv0_mode),
        .slv0_proc_val   (slv0_proc_val),
        .slv0_data_valid (slv0_data_valid),
        .slv0_data       (slv0_data),
        .slv0_ready      (slv0_ready),
        .slv1_mode       (slv1_mode),
        .slv1_proc_val   (slv1_proc_val),
        .slv1_data_valid (slv1_data_valid),
        .slv1_data       (slv1_data),
        .slv1_ready      (slv1_ready),
        .core_start      (core_start),
        .core_mode       (core_mode),
        .core_proc_val   (core_proc_val),
        .core_data_valid (core_data_valid),
        .core_data       (core_data),
        .core_ready      (core_ready),
        .core_cmplt      (core_cmplt),
        .grant           (grant),
        .busy            (busy),
        .job_beats       (job_beats),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before the sequence ended");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every job start and every handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) begin
                if (cfgQ.size() == 0) begin
                    checkOutput("cfgQueue", cfgQ.size(), 1);
                end else begin
                    monCfg = cfgQ.pop_front();
                    checkOutput("cfgGrant", grant, monCfg.g);
                    checkOutput("cfgMode", core_mode, monCfg.m);
                    checkOutput("cfgProcVal", core_proc_val, monCfg.p);
                end
            end
            if (core_data_valid && core_ready) begin
                if (dataQ.size() == 0) begin
                    checkOutput("dataQueue", dataQ.size(), 1);
                end else begin
                    monData = dataQ.pop_front();
                    checkOutput("beatData", core_data, monData);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setSlave(input int s, input logic v, input logic [1:0] m, input logic [CS-1:0] p);
        if (s == 0) begin
            slv0_data_valid = v; slv0_mode = m; slv0_proc_val = p;
        end else begin
            slv1_data_valid = v; slv1_mode = m; slv1_proc_val = p;
        end
    endtask

    task automatic setValid(input int s, input logic v);
        if (s == 0) slv0_data_valid = v;
        else        slv1_data_valid = v;
    endtask

    task automatic setData(input int s, input logic [DW-1:0] d);
        if (s == 0) slv0_data = d;
        else        slv1_data = d;
    endtask

    task automatic pushCfg(input int s, input logic [1:0] m, input logic [CS-1:0] p);
        cfgExp_t e;
        e.g = (s == 0) ? 2'b01 : 2'b10;
        e.m = m;
        e.p = p;
        cfgQ.push_back(e);
    endtask

    task automatic applyStimulus(input int s, input logic [1:0] m, input logic [CS-1:0] p);
        setSlave(s, 1'b1, m, p);
        pushCfg(s, m, p);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        slv0_data_valid = 1'b0; slv1_data_valid = 1'b0;
        core_ready = 1'b0; core_cmplt = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Entered during the CFG cycle of slave s; streams nBeats and ends the job.
    task automatic runJob(input int s, input int nBeats, input bit coincident);
        logic [DW-1:0] d;
        core_ready = 1'b1;
        tick();
        for (int i = 0; i < nBeats; i++) begin
            d = $urandom;
            setData(s, d);
            dataQ.push_back(d);
            if (coincident && i == nBeats - 1) core_cmplt = 1'b1;
            @(negedge clk);
            checkOutput("grantedReady", (s == 0) ? slv0_ready : slv1_ready, 1);
            checkOutput("otherReady", (s == 0) ? slv1_ready : slv0_ready, 0);
            tick();
        end
        if (!coincident) begin
            setValid(s, 1'b0);
            core_cmplt = 1'b1;
            tick();
        end
        core_cmplt = 1'b0;
        core_ready = 1'b0;
        setValid(s, 1'b0);
        @(negedge clk);
        checkOutput("relGrant", grant, 0);
        checkOutput("relBusy", busy, 0);
        checkOutput("jobBeats", job_beats, nBeats);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [1:0]    pattern [4];
        pattern = '{2'd1, 2'd0, 2'd1, 2'd0};

        rst = 1'b1;
        slv0_mode = 2'd3; slv0_proc_val = 8'hFF; slv0_data_valid = 1'b1; slv0_data = 32'hDEADBEEF;
        slv1_mode = 2'd3; slv1_proc_val = 8'hFF; slv1_data_valid = 1'b1; slv1_data = 32'hCAFEF00D;
        core_ready = 1'b1; core_cmplt = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstStart", core_start, 0);
        checkOutput("rstMode", core_mode, 0);
        checkOutput("rstProcVal", core_proc_val, 0);
        checkOutput("rstJobBeats", job_beats, 0);
        checkOutput("rstTimeout", timeout_err, 0);
        checkOutput("rstRdy0", slv0_ready, 0);
        checkOutput("rstRdy1", slv1_ready, 0);
        checkOutput("rstCoreValid", core_data_valid, 0);
        checkOutput("rstCoreData", core_data, 0);
        applyReset();

        $display("[TB] single request");
        tick();
        applyStimulus(0, 2'd2, 8'h40);
        tick();
        @(negedge clk);
        checkOutput("reqGrant", grant, 2'b01);
        checkOutput("reqStart", core_start, 1);
        checkOutput("cfgNoValid", core_data_valid, 0);
        checkOutput("cfgNoData", core_data, 0);
        runJob(0, 4, 1'b0);
        checkOutput("holdMode", core_mode, 2'd2);
        checkOutput("holdProcVal", core_proc_val, 8'h40);

        $display("[TB] completion coincident with last beat");
        applyStimulus(1, 2'd1, 8'h7E);
        tick();
        runJob(1, 3, 1'b1);

        $display("[TB] completion while idle");
        core_cmplt = 1'b1;
        tick();
        tick();
        core_cmplt = 1'b0;
        @(negedge clk);
        checkOutput("idleCmpltBusy", busy, 0);
        checkOutput("idleCmpltGrant", grant, 0);
        checkOutput("idleCmpltBeats", job_beats, 3);

        $display("[TB] contention");
        applyReset();
        applyStimulus(0, 2'd1, 8'h10);
        setSlave(1, 1'b1, 2'd2, 8'h20);
        tick();
        @(negedge clk);
        checkOutput("cont1Grant", grant, 2'b01);
        runJob(0, 2, 1'b0);
        setSlave(0, 1'b1, 2'd3, 8'h30);
        pushCfg(1, 2'd2, 8'h20);
        tick();
        @(negedge clk);
        checkOutput("cont2Grant", grant, 2'b10);
        runJob(1, 3, 1'b1);
        setValid(1, 1'b1);
        pushCfg(0, 2'd3, 8'h30);
        tick();
        @(negedge clk);
        checkOutput("cont3Grant", grant, 2'b01);
        runJob(0, 1, 1'b0);
        setValid(1, 1'b0);

        $display("[TB] backpressure");
        tick();
        applyStimulus(0, 2'd1, 8'h11);
        tick();
        setSlave(1, 1'b1, 2'd3, 8'h99);
        core_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            core_ready = pattern[i][0];
            d = $urandom;
            setData(0, d);
            if (pattern[i][0]) dataQ.push_back(d);
            @(negedge clk);
            checkOutput("bpRdy0", slv0_ready, pattern[i][0]);
            checkOutput("bpRdy1", slv1_ready, 0);
            tick();
        end
        setValid(0, 1'b0);
        core_ready = 1'b0;
        core_cmplt = 1'b1;
        tick();
        core_cmplt = 1'b0;
        @(negedge clk);
        checkOutput("bpBeats", job_beats, 2);
        checkOutput("bpGrant", grant, 0);

        $display("[TB] reset mid-job");
        pushCfg(1, 2'd3, 8'h99);
        tick();
        core_ready = 1'b1;
        d = $urandom;
        setData(1, d);
        dataQ.push_back(d);
        tick();
        @(negedge clk);
        checkOutput("midGrant", grant, 2'b10);
        checkOutput("midRdy1", slv1_ready, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncGrant", grant, 0);
        checkOutput("asyncBusy", busy, 0);
        checkOutput("asyncRdy1", slv1_ready, 0);
        checkOutput("asyncValid", core_data_valid, 0);
        applyReset();

        $display("[TB] stalled job");
        applyStimulus(0, 2'd3, 8'hA5);
        tick();
        core_cmplt = 1'b1;
        core_ready = 1'b0;
        tick();
        core_cmplt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("stallTmo", timeout_err, 0);
            checkOutput("stallBusy", busy, 1);
            tick();
        end
        @(negedge clk);
        checkOutput("stallLastBusy", busy, 1);
        tick();
        @(negedge clk);
        checkOutput("tmoPulse", timeout_err, 1);
        checkOutput("tmoGrant", grant, 0);
        checkOutput("tmoBusy", busy, 0);
        applyStimulus(1, 2'd2, 8'h5A);
        tick();
        @(negedge clk);
        checkOutput("tmoPulseEnd", timeout_err, 0);
        checkOutput("tmoNextGrant", grant, 2'b10);
        setValid(0, 1'b0);
        runJob(1, 2, 1'b0);
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("stallTmo", timeout_err, 0);
            checkOutput("stallGrant", grant, 2'b01);
            checkOutput("stallBusy", busy, 1);
            tick();
        end
        setValid(0, 1'b0);
        core_cmplt = 1'b1;
        tick();
        core_cmplt = 1'b0;
        @(negedge clk);
        checkOutput("stallEndGrant", grant, 0);
        checkOutput("stallEndBeats", job_beats, 0);
`endif

        tick();
        checkOutput("cfgQLeft", cfgQ.size(), 0);
        checkOutput("dataQLeft", dataQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/img_proc_arbiter.md
# img_proc_arbiter

- Shares the single image-processing core between the two slave ports, slv0 and slv1, on a whole-job basis.
- Round-robin selects one slave and latches its mode and processing value into the core configuration.
- Routes that slave's data stream to the core, holding the grant until the core reports completion.
- Sits between the slave interfaces and the processing core inside the accelerator top.

## Interface
- DATA_WIDTH, 32: pixel data bus width.
- COLOR_SIZE, 8: processing-value width.
- TIMEOUT_CYCLES, 1024: stall limit for the watchdog; used only with the macro.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- slv0_mode  in  2  requested operation, slave 0.
- slv0_proc_val  in  COLOR_SIZE  operation operand, slave 0.
- slv0_data_valid  in  1  slave 0 has data; also acts as the job request.
- slv0_data  in  DATA_WIDTH  slave 0 pixel data.
- slv0_ready  out  1  slave 0 beat accepted.
- slv1_mode, slv1_proc_val, slv1_data_valid, slv1_data, slv1_ready: same as slave 0, for slave 1.
- core_start  out  1  one-cycle job-start pulse.
- core_mode  out  2  latched mode.
- core_proc_val  out  COLOR_SIZE  latched operand.
- core_data_valid  out  1  granted slave's valid.
- core_data  out  DATA_WIDTH  granted slave's data.
- core_ready  in  1  core accepts a beat.
- core_cmplt  in  1  core job finished.
- grant  out  2  one-hot owner (bit0 = slv0).
- busy  out  1  job in progress.
- job_beats  out  16  beats transferred in the current or last job.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, CFG, ACTIVE.
- IDLE:
  - If any slvN_data_valid is high, pick a slave via the round-robin pointer (rr_ptr).
  - Latch that slave's mode and proc_val into core_mode/core_proc_val, set grant, clear job_beats, go to CFG.
- Arbitration:
  - Only one slave valid: that slave wins, regardless of rr_ptr.
  - Both valid: the slave equal to rr_ptr wins.
  - rr_ptr resets to 0.
  - On every job end (completion or abort), rr_ptr becomes the index of the non-granted slave.
- CFG: core_start = 1 for exactly this cycle; busy = 1; next state ACTIVE.
- ACTIVE:
  - core_data_valid/core_data are combinationally muxed from the granted slave.
  - slvG_ready = core_ready for the granted slave; the other slave's ready = 0.
  - job_beats increments on each core_data_valid && core_ready, saturating at 16'hFFFF.
- Job end: core_cmplt in ACTIVE → IDLE, grant = 0, busy = 0.
- core_cmplt in IDLE or CFG is ignored.
- core_mode, core_proc_val and job_beats hold their values after the job until the next grant.
- Outside ACTIVE, core_data_valid = 0, both slvN_ready = 0, and core_data = 0.
- Simultaneous final beat and core_cmplt: the beat is counted, then the FSM goes to IDLE.
- Reset mid-job: all state clears immediately, asynchronously. Combinational outputs drop with the state, and the slave must restart its job.

## Timing
- Reset values: grant 0, busy 0, core_start 0, core_mode 0, core_proc_val 0, job_beats 0, timeout_err 0, slvN_ready 0, core_data_valid 0, core_data 0.
- Request latency: slvN_data_valid is sampled high in IDLE at edge N.
  - grant and core_start are high after edge N.
  - The first beat can pass after edge N+1.
- Data path: zero added latency in ACTIVE, purely combinational mux.
- Release: core_cmplt is sampled at edge M; grant = 0 after M. The next grant is possible after M+1 (one IDLE cycle minimum).
- All registered outputs update on the rising edge of clk.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on every ACTIVE beat and on entry to ACTIVE, and increments on each ACTIVE cycle without a beat.
  - When the counter reaches TIMEOUT_CYCLES: pulse timeout_err for 1 cycle, go to IDLE, grant = 0, busy = 0, advance rr_ptr.
  - core_cmplt in the same cycle wins: normal completion, no error.
- ARB_TIMEOUT_EN undefined: no counter is built, timeout_err is tied to 0, and a grant is held indefinitely until core_cmplt.

## Structure
- Package img_arb_pkg holds:
  - the state enum (IDLE, CFG, ACTIVE);
  - the default COLOR_SIZE constant;
  - the 2-bit one-hot grant type;
  - the job_beats width constant (16).
- Sub-module rr_arbiter2: two-request round-robin picker.
  - Inputs: req[1:0], rr_ptr.
  - Output: one-hot pick.
  - Purely combinational.
- The top level holds the FSM, config latches, beat counter and watchdog.

## Test plan
- Reset then single request:
  - Stimulus: slv0_data_valid = 1, mode = 2, proc_val = 8'h40.
  - Response: one cycle later grant = 01, core_start = 1, core_mode = 2, core_proc_val = 8'h40.
  - 4 beats with core_ready = 1, then core_cmplt: job_beats = 4, grant returns to 00.
- Contention:
  - Stimulus: both slaves valid from reset.
  - Response: slv0 is granted first; after its core_cmplt, slv1 is granted after one IDLE cycle; the third grant goes to slv0.
- Backpressure:
  - Stimulus: core_ready toggles 1,0,1,0 during ACTIVE.
  - Response: slv0_ready mirrors it, slv1_ready stays 0, job_beats counts only handshakes (2).
- Edge cases:
  - core_cmplt coincident with the last beat: beat counted, then IDLE.
  - core_cmplt pulsed in IDLE: no effect.
- Reset mid-job:
  - Stimulus: rst asserted between edges during ACTIVE.
  - Response: grant, busy and slvN_ready are 0 immediately, with no clock edge.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8:
  - Stimulus: granted, core_ready held 0.
  - Response: timeout_err pulses 8 ACTIVE cycles after CFG, grant = 00, and the other slave is favored next.
